// File: rtl/tdp_bram_bytewise_init_if.sv
// Bundle of the two RAM ports plus the clear/collision side-band signals.
//   master : driven by the loader/datapath side (enables, byte write enables, addresses, data, init_req)
//   slave  : the RAM itself (read data, valids, init_busy, collision, collision_err)
interface tdp_bram_bytewise_init_if #(
    parameter int RAM_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    localparam int NB = RAM_WIDTH / 8;

    logic                  init_req;
    logic                  init_busy;
    logic                  collision;
    logic                  collision_err;

    logic                  ena;
    logic [NB-1:0]         wea;
    logic [ADDR_WIDTH-1:0] addra;
    logic [RAM_WIDTH-1:0]  dina;
    logic [RAM_WIDTH-1:0]  douta;
    logic                  douta_valid;

    logic                  enb;
    logic [NB-1:0]         web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [RAM_WIDTH-1:0]  dinb;
    logic [RAM_WIDTH-1:0]  doutb;
    logic                  doutb_valid;

    modport master (
        output init_req, ena, wea, addra, dina, enb, web, addrb, dinb,
        input  init_busy, collision, collision_err, douta, douta_valid, doutb, doutb_valid
    );

    modport slave (
        input  init_req, ena, wea, addra, dina, enb, web, addrb, dinb,
        output init_busy, collision, collision_err, douta, douta_valid, doutb, doutb_valid
    );
endinterface

// File: rtl/tdp_bram_bytewise_init.sv
// True dual-port RAM (single clock) with per-byte write enables, selectable
// write mode, 1/2-cycle read latency with valid pulses, same-address
// collision detection and a zero-clear sequencer.
// Ports:
//   clk  : clock for both ports
//   rst  : asynchronous reset, active high
//   bus  : slave side of tdp_bram_bytewise_init_if (ports A/B, init_req,
//          init_busy, collision, collision_err)
module tdp_bram_bytewise_init #(
    parameter int RAM_WIDTH      = 32,
    parameter int RAM_DEPTH      = 1024,
    parameter int ADDR_WIDTH     = $clog2(RAM_DEPTH),
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    tdp_bram_bytewise_init_if.slave  bus
);
    localparam int NB = RAM_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CMP = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] clr_addr_r, clr_addr_s;
    logic [RAM_WIDTH-1:0]  mem_r [RAM_DEPTH];

    logic                  busy_s, init_acc_s;
    logic                  acc_a_s, acc_b_s, wr_a_s, wr_b_s, inr_a_s, inr_b_s;
    logic                  same_s, coll_s, launch_a_s, launch_b_s;
    logic [RAM_WIDTH-1:0]  old_a_s, old_b_s, post_a_s, post_b_s, rd_a_s, rd_b_s;

    logic                  v1a_r, v1b_r, v2a_r, v2b_r;
    logic [RAM_WIDTH-1:0]  d1a_r, d1b_r, d2a_r, d2b_r;
    logic                  collision_r, collision_err_r;

    // Overlay the enabled bytes of din onto base.
    function automatic logic [RAM_WIDTH-1:0] merge_bytes(
        input logic [RAM_WIDTH-1:0] base,
        input logic [RAM_WIDTH-1:0] din,
        input logic [NB-1:0]        be
    );
        logic [RAM_WIDTH-1:0] res;
        res = base;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = din[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Sequencer state and clear address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RST_STATE;
            clr_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            clr_addr_r <= clr_addr_s;
        end
    end

    // Next-state logic: a clear walks every address once, then returns to IDLE.
    always_comb begin
        state_s    = state_r;
        clr_addr_s = clr_addr_r;
        case (state_r)
            ST_IDLE: begin
                clr_addr_s = {ADDR_WIDTH{1'b0}};
                if (bus.init_req) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) begin
                    state_s    = ST_IDLE;
                    clr_addr_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    state_s    = ST_CLEAR;
                    clr_addr_s = clr_addr_r + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                clr_addr_s = {ADDR_WIDTH{1'b0}};
            end
        endcase
    end

    assign busy_s     = (state_r == ST_CLEAR);
    assign init_acc_s = (state_r == ST_IDLE) && bus.init_req;

    // Access decode. On a same-address access the final word is B's bytes
    // laid on the old word, then A's bytes on top, so A wins shared bytes;
    // both ports then see (and write) the same merged word.
    always_comb begin
        acc_a_s  = bus.ena && !busy_s;
        acc_b_s  = bus.enb && !busy_s;
        wr_a_s   = acc_a_s && (|bus.wea);
        wr_b_s   = acc_b_s && (|bus.web);
        inr_a_s  = ({1'b0, bus.addra} < DEPTH_CMP);
        inr_b_s  = ({1'b0, bus.addrb} < DEPTH_CMP);
        old_a_s  = inr_a_s ? mem_r[bus.addra] : {RAM_WIDTH{1'b0}};
        old_b_s  = inr_b_s ? mem_r[bus.addrb] : {RAM_WIDTH{1'b0}};
        same_s   = acc_a_s && acc_b_s && (bus.addra == bus.addrb) && inr_a_s;
        coll_s   = same_s && ((|bus.wea) || (|bus.web));
        post_a_s = merge_bytes(same_s ? merge_bytes(old_a_s, bus.dinb, bus.web) : old_a_s,
                               bus.dina, bus.wea);
        post_b_s = same_s ? post_a_s : merge_bytes(old_b_s, bus.dinb, bus.web);
        rd_a_s   = !inr_a_s ? {RAM_WIDTH{1'b0}} :
                   ((wr_a_s && (WRITE_MODE == 1)) ? post_a_s : old_a_s);
        rd_b_s   = !inr_b_s ? {RAM_WIDTH{1'b0}} :
                   ((wr_b_s && (WRITE_MODE == 1)) ? post_b_s : old_b_s);
        launch_a_s = acc_a_s && !(wr_a_s && (WRITE_MODE == 2));
        launch_b_s = acc_b_s && !(wr_b_s && (WRITE_MODE == 2));
    end

    // Storage array: clear writes, or up to two port writes (out-of-range writes dropped).
    always_ff @(posedge clk) begin
        if (busy_s) begin
            mem_r[clr_addr_r] <= {RAM_WIDTH{1'b0}};
        end else begin
            if (wr_a_s && inr_a_s) begin
                mem_r[bus.addra] <= post_a_s;
            end
            if (wr_b_s && inr_b_s) begin
                mem_r[bus.addrb] <= post_b_s;
            end
        end
    end

    // Read pipelines; data registers only load with a valid so outputs hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1a_r <= 1'b0;
            v1b_r <= 1'b0;
            v2a_r <= 1'b0;
            v2b_r <= 1'b0;
            d1a_r <= {RAM_WIDTH{1'b0}};
            d1b_r <= {RAM_WIDTH{1'b0}};
            d2a_r <= {RAM_WIDTH{1'b0}};
            d2b_r <= {RAM_WIDTH{1'b0}};
        end else begin
            v1a_r <= launch_a_s;
            v1b_r <= launch_b_s;
            v2a_r <= v1a_r;
            v2b_r <= v1b_r;
            if (launch_a_s) d1a_r <= rd_a_s;
            if (launch_b_s) d1b_r <= rd_b_s;
            if (v1a_r)      d2a_r <= d1a_r;
            if (v1b_r)      d2b_r <= d1b_r;
        end
    end

    // Collision pulse and sticky flag; an accepted init_req clears the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision_r     <= 1'b0;
            collision_err_r <= 1'b0;
        end else begin
            collision_r <= coll_s;
            if (init_acc_s) begin
                collision_err_r <= 1'b0;
            end else if (coll_s) begin
                collision_err_r <= 1'b1;
            end
        end
    end

    assign bus.init_busy     = busy_s;
    assign bus.collision     = collision_r;
    assign bus.collision_err = collision_err_r;
    assign bus.douta         = (READ_LATENCY == 2) ? d2a_r : d1a_r;
    assign bus.doutb         = (READ_LATENCY == 2) ? d2b_r : d1b_r;
    assign bus.douta_valid   = (READ_LATENCY == 2) ? v2a_r : v1a_r;
    assign bus.doutb_valid   = (READ_LATENCY == 2) ? v2b_r : v1b_r;
endmodule

// File: tb/tb_tdp_bram_bytewise_init.sv
// Bench for tdp_bram_bytewise_init. Three instances share one stimulus:
//   dut 0: read-first,  latency 1, depth 16
//   dut 1: write-first, latency 2, depth 16
//   dut 2: no-change,   latency 1, depth 12 (addresses 12..15 are out of range)
// A word-level model predicts every output each cycle; a few literal
// expectations pin the key scenarios.
module tb_tdp_bram_bytewise_init;
    localparam int W  = 32;
    localparam int AW = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        init_req = 1'b0;
    logic        ena = 1'b0, enb = 1'b0;
    logic [3:0]  wea = 4'h0, web = 4'h0;
    logic [3:0]  addra = 4'h0, addrb = 4'h0;
    logic [31:0] dina = 32'h0, dinb = 32'h0;

    logic        busy_o [ND];
    logic        coll_o [ND];
    logic        err_o  [ND];
    logic        va_o   [ND];
    logic        vb_o   [ND];
    logic [31:0] da_o   [ND];
    logic [31:0] db_o   [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        tdp_bram_bytewise_init_if #(.RAM_WIDTH(W), .ADDR_WIDTH(AW)) bus ();
        assign bus.init_req = init_req;
        assign bus.ena      = ena;
        assign bus.wea      = wea;
        assign bus.addra    = addra;
        assign bus.dina     = dina;
        assign bus.enb      = enb;
        assign bus.web      = web;
        assign bus.addrb    = addrb;
        assign bus.dinb     = dinb;
        assign busy_o[k]    = bus.init_busy;
        assign coll_o[k]    = bus.collision;
        assign err_o[k]     = bus.collision_err;
        assign va_o[k]      = bus.douta_valid;
        assign vb_o[k]      = bus.doutb_valid;
        assign da_o[k]      = bus.douta;
        assign db_o[k]      = bus.doutb;
        tdp_bram_bytewise_init #(
            .RAM_WIDTH(W), .RAM_DEPTH((k == 2) ? 12 : 16), .ADDR_WIDTH(AW),
            .READ_LATENCY((k == 1) ? 2 : 1), .WRITE_MODE(k), .CLEAR_ON_RESET(1)
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
    end

    // ---------------- model state ----------------
    int          m_depth [ND] = '{16, 16, 12};
    int          m_lat   [ND] = '{1, 2, 1};
    int          m_mode  [ND] = '{0, 1, 2};
    logic [31:0] m_mem   [ND][16];
    int          m_busy  [ND];
    logic        m_coll  [ND];
    logic        m_err   [ND];
    int          slot_due [ND][2][4];
    logic [31:0] slot_d   [ND][2][4];
    logic [31:0] m_last   [ND][2];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_chk = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", nm, k, cyc, act, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < ND; k++) begin
            m_busy[k] = m_depth[k];
            m_coll[k] = 1'b0;
            m_err[k]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_last[k][p] = 32'h0;
                for (int s = 0; s < 4; s++) slot_due[k][p][s] = -1;
            end
        end
    endtask

    task automatic schedule(input int k, input int p, input logic acc, input logic wr,
                            input logic inr, input logic [31:0] oldw, input logic [31:0] postw);
        int due;
        if (acc && !(wr && m_mode[k] == 2)) begin
            due = cyc + m_lat[k];
            slot_due[k][p][due % 4] = due;
            slot_d[k][p][due % 4]   = !inr ? 32'h0 : ((wr && m_mode[k] == 1) ? postw : oldw);
        end
    endtask

    // What the next clock edge does, from the current inputs.
    task automatic model_step();
        logic acc_a, acc_b, ina, inb;
        logic [31:0] olda, oldb, posta, postb;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < ND; k++) begin
            m_coll[k] = 1'b0;
            if (m_busy[k] > 0) begin
                m_mem[k][m_depth[k] - m_busy[k]] = 32'h0;
                m_busy[k] = m_busy[k] - 1;
            end else begin
                acc_a = ena;
                acc_b = enb;
                ina   = int'(addra) < m_depth[k];
                inb   = int'(addrb) < m_depth[k];
                olda  = ina ? m_mem[k][addra] : 32'h0;
                oldb  = inb ? m_mem[k][addrb] : 32'h0;
                if (acc_a && acc_b && addra == addrb && ina && (wea != 4'h0 || web != 4'h0)) begin
                    m_coll[k] = 1'b1;
                    m_err[k]  = 1'b1;
                end
                // B first, then A, so A owns bytes both enable.
                for (int b = 0; b < 4; b++) begin
                    if (acc_b && inb && web[b]) m_mem[k][addrb][b*8 +: 8] = dinb[b*8 +: 8];
                end
                for (int b = 0; b < 4; b++) begin
                    if (acc_a && ina && wea[b]) m_mem[k][addra][b*8 +: 8] = dina[b*8 +: 8];
                end
                posta = ina ? m_mem[k][addra] : 32'h0;
                postb = inb ? m_mem[k][addrb] : 32'h0;
                schedule(k, 0, acc_a, wea != 4'h0, ina, olda, posta);
                schedule(k, 1, acc_b, web != 4'h0, inb, oldb, postb);
                if (init_req) begin
                    m_busy[k] = m_depth[k];
                    m_err[k]  = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic        ev;
        logic [31:0] ed;
        int          s;
        for (int k = 0; k < ND; k++) begin
            chk("init_busy", k, 32'(busy_o[k]), 32'(m_busy[k] > 0));
            chk("collision", k, 32'(coll_o[k]), 32'(m_coll[k]));
            chk("collision_err", k, 32'(err_o[k]), 32'(m_err[k]));
            for (int p = 0; p < 2; p++) begin
                s = cyc % 4;
                if (!rst && slot_due[k][p][s] == cyc) begin
                    ev = 1'b1;
                    ed = slot_d[k][p][s];
                    m_last[k][p] = ed;
                end else begin
                    ev = 1'b0;
                    if (rst) m_last[k][p] = 32'h0;
                    ed = m_last[k][p];
                end
                if (p == 0) begin
                    chk("douta_valid", k, 32'(va_o[k]), 32'(ev));
                    chk("douta", k, da_o[k], ed);
                end else begin
                    chk("doutb_valid", k, 32'(vb_o[k]), 32'(ev));
                    chk("doutb", k, db_o[k], ed);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
        compare_all();
        #1;
    endtask

    task automatic idle();
        init_req = 1'b0;
        ena = 1'b0; wea = 4'h0;
        enb = 1'b0; web = 4'h0;
    endtask

    task automatic port_a(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
        ena = 1'b1; addra = a; wea = we; dina = d;
    endtask

    task automatic port_b(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
        enb = 1'b1; addrb = a; web = we; dinb = d;
    endtask

    task automatic wait_clear(input string nm, input int exp_cycles);
        int n;
        n = 0;
        while (busy_o[0] && n < 100) begin
            tick();
            n = n + 1;
        end
        chk(nm, 0, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        rst = 1'b0;

        // Power-on clear, then every address reads zero one cycle later.
        wait_clear("clear_cycles_after_reset", 16);
        for (int a = 0; a < 16; a++) begin
            port_a(4'(a), 4'h0, 32'h0);
            tick();
            chk("cleared_word", 0, da_o[0], 32'h0000_0000);
            chk("cleared_valid", 0, 32'(va_o[0]), 32'h1);
        end
        idle();
        tick();

        // Byte-enable merge and latency-2 valid timing.
        port_a(4'd5, 4'hF, 32'hDEAD_BEEF);
        tick();
        port_a(4'd5, 4'h3, 32'h1111_2222);
        tick();
        idle();
        port_b(4'd5, 4'h0, 32'h0);
        tick();
        idle();
        chk("merge_lat1", 0, db_o[0], 32'hDEAD_2222);
        chk("lat2_not_yet", 1, 32'(vb_o[1]), 32'h0);
        tick();
        chk("lat2_valid", 1, 32'(vb_o[1]), 32'h1);
        chk("merge_lat2", 1, db_o[1], 32'hDEAD_2222);

        // Write modes: overwrite 0x12345678 with 0xA5A5A5A5.
        port_a(4'd3, 4'hF, 32'h1234_5678);
        tick();
        port_a(4'd3, 4'h0, 32'h0);
        tick();
        port_a(4'd3, 4'hF, 32'hA5A5_A5A5);
        tick();
        idle();
        chk("read_first", 0, da_o[0], 32'h1234_5678);
        chk("no_change_valid", 2, 32'(va_o[2]), 32'h0);
        chk("no_change_hold", 2, da_o[2], 32'h1234_5678);
        tick();
        chk("write_first", 1, da_o[1], 32'hA5A5_A5A5);

        // Both ports write addr 7.
        port_a(4'd7, 4'h5, 32'hAAAA_AAAA);
        port_b(4'd7, 4'hF, 32'hBBBB_BBBB);
        tick();
        idle();
        chk("coll_pulse", 0, 32'(coll_o[0]), 32'h1);
        tick();
        chk("coll_pulse_end", 0, 32'(coll_o[0]), 32'h0);
        chk("coll_sticky", 0, 32'(err_o[0]), 32'h1);
        port_a(4'd7, 4'h0, 32'h0);
        tick();
        idle();
        chk("coll_merge", 0, da_o[0], 32'hBBAA_BBAA);
        chk("model_merge", 0, m_mem[0][7], 32'hBBAA_BBAA);

        // Same out-of-range address on the depth-12 instance: no collision there.
        port_a(4'd13, 4'hF, 32'h1313_1313);
        port_b(4'd13, 4'hF, 32'h3131_3131);
        tick();
        idle();
        chk("oor_no_coll", 2, 32'(coll_o[2]), 32'h0);
        chk("inr_coll", 0, 32'(coll_o[0]), 32'h1);
        port_b(4'd13, 4'h0, 32'h0);
        tick();
        idle();
        chk("oor_read_zero", 2, db_o[2], 32'h0);
        chk("oor_read_valid", 2, 32'(vb_o[2]), 32'h1);

        // Reader against writer on addr 9, then two readers.
        port_a(4'd9, 4'hF, 32'h0000_0001);
        tick();
        port_a(4'd9, 4'hF, 32'h0F0F_0F0F);
        port_b(4'd9, 4'h0, 32'h0);
        tick();
        idle();
        chk("reader_pre_write", 0, db_o[0], 32'h0000_0001);
        chk("rw_coll", 0, 32'(coll_o[0]), 32'h1);
        port_a(4'd9, 4'h0, 32'h0);
        port_b(4'd9, 4'h0, 32'h0);
        tick();
        idle();
        chk("rr_no_coll", 0, 32'(coll_o[0]), 32'h0);
        chk("rr_data", 0, da_o[0], 32'h0F0F_0F0F);

        // init_req with a read in the same cycle; the read still completes.
        init_req = 1'b1;
        port_a(4'd9, 4'h0, 32'h0);
        tick();
        idle();
        chk("init_busy", 0, 32'(busy_o[0]), 32'h1);
        chk("init_clears_err", 0, 32'(err_o[0]), 32'h0);
        chk("inflight_read", 0, da_o[0], 32'h0F0F_0F0F);
        port_a(4'd2, 4'hF, 32'hFFFF_FFFF);
        repeat (4) tick();

        // Reset mid-clear: clear restarts and runs the full depth; writes during busy ignored.
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", 0, 32'(busy_o[0]), 32'h1);
        repeat (2) tick();
        rst = 1'b0;
        wait_clear("clear_cycles_restart", 16);
        idle();
        port_a(4'd2, 4'h0, 32'h0);
        tick();
        chk("busy_write_ignored", 0, da_o[0], 32'h0);
        port_a(4'd9, 4'h0, 32'h0);
        tick();
        idle();
        chk("restart_cleared", 0, da_o[0], 32'h0);

        // Reset with a valid on the output: it drops at once.
        port_a(4'd7, 4'hF, 32'h7777_7777);
        tick();
        port_a(4'd7, 4'h0, 32'h0);
        tick();
        idle();
        chk("pre_rst_valid", 0, 32'(va_o[0]), 32'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid_drop", 0, 32'(va_o[0]), 32'h0);
        chk("rst_dout_zero", 0, da_o[0], 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        wait_clear("clear_cycles_final", 16);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
